// File: rtl/spell_pkg.sv
// Shared definitions for the SPELL rambus bridge.
//   bridge_state_t : request sequencing states (idle, bus cycle open, response)
//   CNT_W          : width of the stall counter, sized for the largest legal TIMEOUT
//   lane_sel()     : one-hot Wishbone byte select for a byte lane
//   lane_byte()    : little-endian byte extraction from a 32-bit word
package spell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_t;

    localparam int TIMEOUT_MAX = 255;
    localparam int CNT_W       = $clog2(TIMEOUT_MAX + 1);

    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/spell_rambus_bridge.sv
// Byte-request to 32-bit classic Wishbone bridge for the SPELL core memory port.
// Keeps a single-word write-through read buffer, aborts bus cycles that stall
// for TIMEOUT cycles and reports those as error responses.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   req_valid/ready/we/addr/wdata  core request (byte address, lane in [1:0])
//   rsp_valid/rdata/err            one-cycle completion pulse with read byte / error
//   invalidate                     drops the read buffer (RAM changed by another master)
//   timeout_flag, timeout_clear    sticky timeout indication and its clear
//   rambus_wb_*                    classic Wishbone master towards OpenRAM
module spell_rambus_bridge
    import spell_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 16,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    input  logic              invalidate,
    output logic              timeout_flag,
    input  logic              timeout_clear,
    output logic              rambus_wb_clk_o,
    output logic              rambus_wb_rst_o,
    output logic              rambus_wb_stb_o,
    output logic              rambus_wb_cyc_o,
    output logic              rambus_wb_we_o,
    output logic [3:0]        rambus_wb_sel_o,
    output logic [31:0]       rambus_wb_dat_o,
    output logic [ADDR_W-1:0] rambus_wb_addr_o,
    input  logic              rambus_wb_ack_i,
    input  logic [31:0]       rambus_wb_dat_i
);

    bridge_state_t     state_reg, state_next;

    logic              cyc_reg;
    logic              we_reg;
    logic [3:0]        sel_reg;
    logic [31:0]       dat_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        lane_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              inv_pend_reg;   // invalidate seen while the current cycle was open

    logic [31:0]       buf_data_reg;
    logic [ADDR_W-1:0] buf_tag_reg;
    logic              buf_valid_reg;

    logic              rsp_valid_reg;
    logic [7:0]        rsp_rdata_reg;
    logic              rsp_err_reg;
    logic              tflag_reg;

    logic [ADDR_W-1:0] req_word;
    logic [1:0]        req_lane;
    logic              accept;
    logic              hit;
    logic              ack_done;
    logic              tmo;
    logic [31:0]       merged_word;

    assign req_word = req_addr[ADDR_W+1:2];
    assign req_lane = req_addr[1:0];

    // Write-through: the written byte lane replaces the buffered byte, others kept.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[gi*8 +: 8] = sel_reg[gi] ? dat_reg[gi*8 +: 8]
                                                        : buf_data_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        hit        = 1'b0;
        ack_done   = 1'b0;
        tmo        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (CACHE_EN && !req_we && buf_valid_reg && (buf_tag_reg == req_word)) begin
                        hit        = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // An ack arriving in the last allowed cycle still completes normally.
                if (rambus_wb_ack_i) begin
                    ack_done   = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    tmo        = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sel_reg       <= 4'b0;
            dat_reg       <= 32'b0;
            addr_reg      <= '0;
            lane_reg      <= 2'b0;
            cnt_reg       <= '0;
            inv_pend_reg  <= 1'b0;
            buf_data_reg  <= 32'b0;
            buf_tag_reg   <= '0;
            buf_valid_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            rsp_err_reg   <= 1'b0;
            tflag_reg     <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            rsp_err_reg   <= 1'b0;

            if (accept && hit) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= lane_byte(buf_data_reg, req_lane);
            end

            if (accept && !hit) begin
                cyc_reg      <= 1'b1;
                we_reg       <= req_we;
                sel_reg      <= lane_sel(req_lane);
                addr_reg     <= req_word;
                dat_reg      <= {4{req_wdata}};
                lane_reg     <= req_lane;
                cnt_reg      <= '0;
                inv_pend_reg <= 1'b0;
            end

            if (state_reg == ST_BUS) begin
                if (invalidate) begin
                    inv_pend_reg <= 1'b1;
                end
                if (!ack_done && !tmo) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            if (ack_done) begin
                cyc_reg       <= 1'b0;
                rsp_valid_reg <= 1'b1;
                if (!we_reg) begin
                    rsp_rdata_reg <= lane_byte(rambus_wb_dat_i, lane_reg);
                    if (CACHE_EN) begin
                        buf_data_reg  <= rambus_wb_dat_i;
                        buf_tag_reg   <= addr_reg;
                        buf_valid_reg <= !inv_pend_reg;
                    end
                end else if (buf_valid_reg && (buf_tag_reg == addr_reg)) begin
                    buf_data_reg <= merged_word;
                end
            end

            if (tmo) begin
                cyc_reg       <= 1'b0;
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= 1'b1;
                buf_valid_reg <= 1'b0;
                tflag_reg     <= 1'b1;
            end else if (timeout_clear) begin
                tflag_reg <= 1'b0;
            end

            // Last assignment so it overrides a fill landing in the same cycle.
            if (invalidate) begin
                buf_valid_reg <= 1'b0;
            end
        end
    end

    assign req_ready        = (state_reg == ST_IDLE);
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_rdata        = rsp_rdata_reg;
    assign rsp_err          = rsp_err_reg;
    assign timeout_flag     = tflag_reg;
    assign rambus_wb_clk_o  = clock;
    assign rambus_wb_rst_o  = ~reset_n;
    assign rambus_wb_stb_o  = cyc_reg;
    assign rambus_wb_cyc_o  = cyc_reg;
    assign rambus_wb_we_o   = we_reg;
    assign rambus_wb_sel_o  = sel_reg;
    assign rambus_wb_dat_o  = dat_reg;
    assign rambus_wb_addr_o = addr_reg;

endmodule
